// File: rtl/nb_chest_pkg.sv
// Shared constants, state type and helpers for the
// NB-IoT channel-estimate frequency interpolator.
package nb_chest_pkg;

  localparam int WIDTH_EST     = 17;
  localparam int N_SC          = 12;
  localparam int PILOT_SPACING = 3;
  localparam int THIRD_Q16     = 21845;
  localparam int ROUND_Q16     = 32768;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // a - b one bit wider than the operands, so it never wraps
  function automatic logic signed [WIDTH_EST:0] pdiff(
    input logic signed [WIDTH_EST-1:0] a,
    input logic signed [WIDTH_EST-1:0] b
  );
    return (WIDTH_EST+1)'(a) - (WIDTH_EST+1)'(b);
  endfunction

endpackage

// File: rtl/chest_interp_point.sv
// One interpolated sample: base + round(j*delta/3),
// saturated to the signed estimate range.
module chest_interp_point
  import nb_chest_pkg::*;
(
  input  logic signed [WIDTH_EST-1:0] base_i,
  input  logic signed [WIDTH_EST:0]   delta_i,
  input  logic        [1:0]           j_i,
  output logic signed [WIDTH_EST-1:0] sample_o
);

  localparam int PW = WIDTH_EST + 20;
  localparam logic signed [PW-1:0] SMAX =
    PW'((1 <<< (WIDTH_EST-1)) - 1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  logic signed [WIDTH_EST+1:0] x;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        third;
  logic signed [PW-1:0]        sum;

  always_comb begin
    unique case (j_i)
      2'd1:    x = {delta_i[WIDTH_EST], delta_i};
      2'd2:    x = {delta_i, 1'b0};
      default: x = '0;
    endcase
    prod  = PW'(x) * PW'(THIRD_Q16) + PW'(ROUND_Q16);
    third = prod >>> 16;
    sum   = PW'(base_i) + third;
    if (sum > SMAX) begin
      sample_o = SMAX[WIDTH_EST-1:0];
    end else if (sum < SMIN) begin
      sample_o = SMIN[WIDTH_EST-1:0];
    end else begin
      sample_o = sum[WIDTH_EST-1:0];
    end
  end

endmodule

// File: rtl/chest_freq_interp.sv
// Expands four pilot estimates into 12 subcarrier
// estimates, streamed one per valid/ready handshake.
module chest_freq_interp
  import nb_chest_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH_EST-1:0] h0_re,
  input  logic signed [WIDTH_EST-1:0] h3_re,
  input  logic signed [WIDTH_EST-1:0] h6_re,
  input  logic signed [WIDTH_EST-1:0] h9_re,
  input  logic signed [WIDTH_EST-1:0] h0_im,
  input  logic signed [WIDTH_EST-1:0] h3_im,
  input  logic signed [WIDTH_EST-1:0] h6_im,
  input  logic signed [WIDTH_EST-1:0] h9_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_idx,
  output logic signed [WIDTH_EST-1:0] out_re,
  output logic signed [WIDTH_EST-1:0] out_im,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  state_e state_q;

  logic signed [WIDTH_EST-1:0] hre_q [4];
  logic signed [WIDTH_EST-1:0] him_q [4];

  logic [1:0] p_q, j_q, p_d, j_d;
  logic [3:0] idx_q, idx_d;

  logic signed [WIDTH_EST-1:0] re_q, im_q;
  logic signed [WIDTH_EST-1:0] base_re, base_im;
  logic signed [WIDTH_EST-1:0] samp_re, samp_im;
  logic signed [WIDTH_EST:0]   dlt_re, dlt_im;

  logic valid_q, last_q, busy_q, done_q;

  always_comb begin
    j_d   = (j_q == 2'd2) ? 2'd0 : j_q + 2'd1;
    p_d   = (j_q == 2'd2) ? p_q + 2'd1 : p_q;
    idx_d = {2'b0, p_d} * 4'(PILOT_SPACING)
          + {2'b0, j_d};
    base_re = hre_q[p_d];
    base_im = him_q[p_d];
    // last segment reuses the 6->9 slope to extrapolate
    unique case (p_d)
      2'd0: begin
        dlt_re = pdiff(hre_q[1], hre_q[0]);
        dlt_im = pdiff(him_q[1], him_q[0]);
      end
      2'd1: begin
        dlt_re = pdiff(hre_q[2], hre_q[1]);
        dlt_im = pdiff(him_q[2], him_q[1]);
      end
      default: begin
        dlt_re = pdiff(hre_q[3], hre_q[2]);
        dlt_im = pdiff(him_q[3], him_q[2]);
      end
    endcase
  end

  chest_interp_point u_pt_re (
    .base_i   (base_re),
    .delta_i  (dlt_re),
    .j_i      (j_d),
    .sample_o (samp_re)
  );

  chest_interp_point u_pt_im (
    .base_i   (base_im),
    .delta_i  (dlt_im),
    .j_i      (j_d),
    .sample_o (samp_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) begin
        hre_q[i] <= '0;
        him_q[i] <= '0;
      end
      p_q     <= '0;
      j_q     <= '0;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            hre_q[0] <= h0_re;
            hre_q[1] <= h3_re;
            hre_q[2] <= h6_re;
            hre_q[3] <= h9_re;
            him_q[0] <= h0_im;
            him_q[1] <= h3_im;
            him_q[2] <= h6_im;
            him_q[3] <= h9_im;
            p_q      <= '0;
            j_q      <= '0;
            idx_q    <= '0;
            // offset 0 is the pilot itself
            re_q     <= h0_re;
            im_q     <= h0_im;
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              p_q    <= p_d;
              j_q    <= j_d;
              idx_q  <= idx_d;
              re_q   <= samp_re;
              im_q   <= samp_im;
              last_q <= (idx_d == 4'(N_SC - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_re    = re_q;
  assign out_im    = im_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_chest_freq_interp.sv
// Randomised bench with a transaction-level model of the
// 12-subcarrier interpolation stream.
module tb_chest_freq_interp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic signed [16:0] h0_re = '0, h3_re = '0;
  logic signed [16:0] h6_re = '0, h9_re = '0;
  logic signed [16:0] h0_im = '0, h3_im = '0;
  logic signed [16:0] h6_im = '0, h9_im = '0;
  logic out_valid, out_last, busy, done;
  logic [3:0] out_idx;
  logic signed [16:0] out_re, out_im;

  chest_freq_interp dut (
    .clk(clk), .rst(rst), .start(start),
    .h0_re(h0_re), .h3_re(h3_re),
    .h6_re(h6_re), .h9_re(h9_re),
    .h0_im(h0_im), .h3_im(h3_im),
    .h6_im(h6_im), .h9_im(h9_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_re(out_re),
    .out_im(out_im), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the interpolation rules
  function automatic int third(input longint x);
    longint t;
    t = x * 21845 + 32768;
    return int'(t >>> 16);
  endfunction

  function automatic int samp(input int h[4], input int k);
    int p, j, d, v;
    p = k / 3;
    j = k % 3;
    if (p == 3) d = h[3] - h[2];
    else d = h[p+1] - h[p];
    v = h[p] + third(longint'(j * d));
    if (v > 65535) v = 65535;
    if (v < -65536) v = -65536;
    return v;
  endfunction

  bit m_run = 0;
  bit m_done = 0;
  int m_k = 0;
  int m_re [12];
  int m_im [12];
  bit chk_en = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0;
      m_done = 0;
      m_k = 0;
      for (int i = 0; i < 12; i++) begin
        m_re[i] = 0;
        m_im[i] = 0;
      end
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start) begin
          int hr[4], hi[4];
          hr = '{int'(h0_re), int'(h3_re),
                 int'(h6_re), int'(h9_re)};
          hi = '{int'(h0_im), int'(h3_im),
                 int'(h6_im), int'(h9_im)};
          for (int k = 0; k < 12; k++) begin
            m_re[k] = samp(hr, k);
            m_im[k] = samp(hi, k);
          end
          m_run = 1;
          m_k = 0;
        end
      end else if (out_ready) begin
        if (m_k == 11) begin
          m_run = 0;
          m_done = 1;
        end else begin
          m_k++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", out_valid, m_run);
      check("busy", busy, m_run);
      check("done", done, m_done);
      check("idx", out_idx, m_k);
      check("last", out_last, m_run && m_k == 11);
      check("re", out_re, m_re[m_k]);
      check("im", out_im, m_im[m_k]);
    end
  end

  int cap_re[$];
  int cap_im[$];
  int cap_idx[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      cap_re.push_back(int'(out_re));
      cap_im.push_back(int'(out_im));
      cap_idx.push_back(int'(out_idx));
    end
  end

  int rdy_mode = 0;
  int pat_cnt = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom % 2);
      2: begin
        out_ready = (pat_cnt % 3 == 0);
        pat_cnt++;
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic clear_cap();
    cap_re.delete();
    cap_im.delete();
    cap_idx.delete();
  endtask

  task automatic set_pilots(input int r[4], input int i[4]);
    h0_re = 17'(r[0]); h3_re = 17'(r[1]);
    h6_re = 17'(r[2]); h9_re = 17'(r[3]);
    h0_im = 17'(i[0]); h3_im = 17'(i[1]);
    h6_im = 17'(i[2]); h9_im = 17'(i[3]);
  endtask

  task automatic start_now(input int r[4], input int i[4]);
    set_pilots(r, i);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_start(input int r[4], input int i[4]);
    @(posedge clk);
    #1;
    start_now(r, i);
  endtask

  task automatic wait_done(input int bound, input string tag);
    bit seen;
    seen = 0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no done within %0d cycles", tag, bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ramp[4], five[4], neg[4], zero[4], sat[4];
    int rr[4], ri[4];
    bit hit;
    ramp = '{0, 30, 60, 90};
    five = '{5, 5, 5, 5};
    neg  = '{0, -3, -6, -9};
    zero = '{0, 0, 0, 0};
    sat  = '{0, 0, 0, 65535};

    check("model_ramp4", samp(ramp, 4), 40);
    check("model_neg11", samp(neg, 11), -11);
    check("model_sat10", samp(sat, 10), 65535);

    #1 rst = 1'b1;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_re", out_re, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    clear_cap();
    do_start(ramp, five);
    wait_done(40, "ramp_done");
    check("ramp_n", cap_re.size(), 12);
    for (int k = 0; k < 12 && k < cap_re.size(); k++) begin
      check("ramp_re", cap_re[k], 10 * k);
      check("ramp_im", cap_im[k], 5);
    end

    clear_cap();
    do_start(ramp, five);
    repeat (5) @(posedge clk);
    #1;
    start_now(neg, zero);
    wait_done(40, "ign_done");
    check("ign_n", cap_re.size(), 12);
    if (cap_re.size() == 12) check("ign_re11", cap_re[11], 110);

    clear_cap();
    do_start(neg, zero);
    wait_done(40, "neg_done");
    check("neg_n", cap_re.size(), 12);
    if (cap_re.size() == 12) begin
      check("neg_re1", cap_re[1], -1);
      check("neg_re2", cap_re[2], -2);
      check("neg_re10", cap_re[10], -10);
      check("neg_re11", cap_re[11], -11);
    end

    clear_cap();
    do_start(sat, zero);
    wait_done(40, "sat_done");
    check("sat_n", cap_re.size(), 12);
    if (cap_re.size() == 12) begin
      check("sat_re9", cap_re[9], 65535);
      check("sat_re10", cap_re[10], 65535);
      check("sat_re11", cap_re[11], 65535);
    end

    clear_cap();
    pat_cnt = 0;
    rdy_mode = 2;
    do_start(ramp, five);
    wait_done(100, "bp_done");
    check("bp_n", cap_idx.size(), 12);
    for (int k = 0; k < 12 && k < cap_idx.size(); k++)
      check("bp_idx", cap_idx[k], k);

    rdy_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        rr[i] = int'(17'($urandom)) - 65536 * int'($urandom % 2 == 0);
        ri[i] = $urandom_range(0, 131071) - 65536;
      end
      if (r == 0) do_start(rr, ri);
      else start_now(rr, ri);
      wait_done(200, "rnd_done");
    end

    rdy_mode = 0;
    do_start(ramp, five);
    hit = 0;
    for (int n = 0; n < 30 && !hit; n++) begin
      @(negedge clk);
      if (out_idx == 4'd6) hit = 1;
    end
    check("mid_reach6", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_re", out_re, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    clear_cap();
    do_start(neg, five);
    wait_done(40, "post_rst_done");
    check("post_rst_n", cap_re.size(), 12);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chest_freq_interp.md
Name: chest_freq_interp

Overview:
- Downstream neighbour of the pilot-averaging stage in NB-IoT channel estimation.
- Takes the four averaged pilot-subcarrier estimates (subcarriers 0, 3, 6, 9; real and imaginary) and produces channel estimates for all 12 subcarriers of the RB.
- Uses linear interpolation for 0..8 and linear extrapolation for 10..11.
- Streams results one subcarrier per handshake to the equaliser.

Parameters:
- WIDTH_EST, 17, width of every estimate sample, two's-complement signed (real and imaginary alike).
- N_SC, 12, subcarriers per RB; fixed, not for override.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; pilot inputs valid in the same cycle.
- h0_re, h3_re, h6_re, h9_re  in  WIDTH_EST each  pilot real parts.
- h0_im, h3_im, h6_im, h9_im  in  WIDTH_EST each  pilot imaginary parts.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts sample.
- out_idx  out  4  subcarrier index 0..11 of the current sample.
- out_re, out_im  out  WIDTH_EST each  interpolated estimate.
- out_last  out  1  high with out_idx==11.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, out_idx 0; latched pilots 0. Reset mid-run aborts immediately; no done pulse.
- FSM states: IDLE, RUN.
- IDLE with start=1:
  - Latch all eight pilot inputs.
  - Next cycle: state RUN, busy=1, out_valid=1, out_idx=0, out_re/out_im = sample 0. Latency from start to first valid is 1 cycle.
- RUN:
  - out_valid stays 1 and all out_* stay stable while out_ready=0.
  - A handshake (out_valid & out_ready) advances to the next index, with its registered value, in the next cycle. Sustained throughput is 1 sample/cycle.
- Handshake at idx 11:
  - Next cycle: IDLE, out_valid=0, busy=0, done=1 for exactly one cycle.
  - out_re, out_im, out_idx hold their last values; out_last returns to 0.
- start while in RUN: ignored; latched pilots unchanged.
- start in the cycle done is high (state IDLE): accepted normally.
- Index decomposition: segment p = 0..3 and offset j = 0..2 tracked as counters (no divider); k = 3p + j.
- Base and delta per segment:
  - p=0: base=h0, delta=h3-h0.
  - p=1: base=h3, delta=h6-h3.
  - p=2: base=h6, delta=h9-h6.
  - p=3: base=h9, delta=h9-h6 (extrapolation).
- Arithmetic:
  - delta is computed at WIDTH_EST+1 bits signed, so it never overflows.
  - third(x) = (x*21845 + 32768) >>> 16, arithmetic shift, full-width product.
  - Sample = base + {0, third(delta), third(2*delta)} for j = {0,1,2}.
  - The sum is saturated to the signed WIDTH_EST range [-2^(W-1), 2^(W-1)-1].
- Real and imaginary paths are identical and independent.

Decomposition:
- Package nb_chest_pkg holds:
  - WIDTH_EST and N_SC.
  - PILOT_SPACING=3.
  - THIRD_Q16=21845 and ROUND_Q16=32768.
  - The state enum (IDLE, RUN).
- Sub-module chest_interp_point: combinational.
  - Inputs: base, delta, j.
  - Output: saturated sample.
  - Instantiated twice (re, im).
- FSM, counters and output registers live in the top.

Test Plan:
- Ramp: h_re = 0/30/60/90, h_im = 5 on all four pilots, start, out_ready=1 → out_re 0,10,20,...,110 on consecutive cycles; out_im = 5 throughout; out_last only at idx 11; done 1 cycle later.
- Negative slope: h0_re=0, h3_re=-3, h6_re=-6, h9_re=-9 → idx 1,2 give -1,-2; idx 10,11 give -10,-11.
- Saturation (W=17): h6_re=0, h9_re=65535 → idx 10 and 11 both give 65535; idx 9 gives 65535.
- Backpressure: out_ready toggled 1,0,0,1,... → out_* stable during stalls; no index skipped or repeated; exactly 12 handshakes.
- Start ignored: pulse start with new pilots at idx 5 → remaining samples use the original pilots; a later start after done uses the new pilots.
- Reset mid-run: assert rst at idx 6 → out_valid, busy and done go 0 immediately; after release the block idles until the next start, then produces a full 12-sample run.
